// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and defaults for the dmem load/store unit.
package lsu_pkg;

   localparam int unsigned DMEM_DEPTH_DEF = 33001;
   localparam int unsigned ADDR_W_DEF     = 16;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      MERGE,
      WR,
      RESP
   } state_e;

   // Request fields captured at accept; off is already force-aligned.
   typedef struct packed {
      logic        we;
      size_e       size;
      logic        uns;
      logic [1:0]  off;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: CPU-side request/response bundle of the load/store unit.
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: combinational little-endian lane extract/extend for loads and
// lane merge for sub-word stores.
module lsu_lane
   import lsu_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  off,
   input  logic        uns,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = rdata[{off, 3'b000} +: 8];
   assign half_v = rdata[{off[1], 4'b0000} +: 16];

   // Extend the selected lane for loads; splice store data into the old word.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      load_data  = 32'h0;
      merge_data = rdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{~uns & byte_v[7]}}, byte_v};
            merge_data[{off, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data = {{16{~uns & half_v[15]}}, half_v};
            merge_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
         end
         SZ_WORD: begin
            load_data  = rdata;
            merge_data = wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit in front of a word-wide data memory with a
// one-cycle registered read. Sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses report resp_err
// instead of being force-aligned.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEF,
   parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   dmem_lsu_if.slave         bus,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_data_in,
   output logic              dmem_wr,
   input  logic [31:0]       dmem_data_out
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DMEM_DEPTH);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
   logic [31:0]       dmem_data_in_q, dmem_data_in_d;
   logic              dmem_wr_q, dmem_wr_d;

   size_e             req_size;
   logic [1:0]        off_raw, off_aligned;
   logic [ADDR_W-1:0] word_idx;
   logic              range_err, acc_err;
   logic [31:0]       load_data, merge_data;

   assign req_size  = size_e'(bus.req_size);
   assign off_raw   = bus.req_addr[1:0];
   assign word_idx  = bus.req_addr[ADDR_W+1:2];
   assign range_err = (|bus.req_addr[31:ADDR_W+2]) || ({1'b0, word_idx} >= DEPTH_LIM);

   // Force-align the byte offset; only matters when misalignment is not trapped.
   always_comb begin
      off_aligned = off_raw;
      case (req_size)
         SZ_HALF: off_aligned = {off_raw[1], 1'b0};
         SZ_WORD: off_aligned = 2'b00;
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = ((req_size == SZ_HALF) && off_raw[0]) ||
                     ((req_size == SZ_WORD) && (off_raw != 2'b00));
   assign acc_err  = (req_size == SZ_RSVD) || range_err || misalign;
`else
   assign acc_err  = (req_size == SZ_RSVD) || range_err;
`endif

   lsu_lane u_lane (
      .size       (req_q.size),
      .off        (req_q.off),
      .uns        (req_q.uns),
      .rdata      (dmem_data_out),
      .wdata      (req_q.wdata),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Next-state and next-output logic; pulses default low, the rest hold.
   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      req_ready_d    = req_ready_q;
      resp_valid_d   = 1'b0;
      resp_err_d     = resp_err_q;
      resp_rdata_d   = resp_rdata_q;
      dmem_addr_d    = dmem_addr_q;
      dmem_data_in_d = dmem_data_in_q;
      dmem_wr_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               req_d        = '{we: bus.req_we, size: req_size, uns: bus.req_unsigned,
                                off: off_aligned, wdata: bus.req_wdata};
               req_ready_d  = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = 32'h0;
               if (acc_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  dmem_addr_d = word_idx;
                  if (bus.req_we && (req_size == SZ_WORD)) begin
                     state_d        = WR;
                     dmem_wr_d      = 1'b1;
                     dmem_data_in_d = bus.req_wdata;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: state_d = MERGE;
         MERGE: begin
            if (req_q.we) begin
               state_d        = WR;
               dmem_wr_d      = 1'b1;
               dmem_data_in_d = merge_data;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data;
            end
         end
         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            resp_err_d  = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // State and registered outputs; synchronous reset aborts any operation.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (rst) begin
         state_q        <= IDLE;
         req_q          <= '0;
         req_ready_q    <= 1'b1;
         resp_valid_q   <= 1'b0;
         resp_err_q     <= 1'b0;
         resp_rdata_q   <= 32'h0;
         dmem_addr_q    <= '0;
         dmem_data_in_q <= 32'h0;
         dmem_wr_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_err_q     <= resp_err_d;
         resp_rdata_q   <= resp_rdata_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_data_in_q <= dmem_data_in_d;
         dmem_wr_q      <= dmem_wr_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign dmem_addr      = dmem_addr_q;
   assign dmem_data_in   = dmem_data_in_q;
   assign dmem_wr        = dmem_wr_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and randomized checks of dmem_lsu against a
// behavioural model of the load/store rules and a shadow copy of memory.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_dmem_lsu;

   localparam int DEPTH = 33001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dmem_addr;
   logic [31:0] dmem_data_in;
   logic        dmem_wr;
   logic [31:0] dmem_data_out;

   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = 16'h0;
   logic [31:0] pre_data = 32'h0;

   logic [31:0] mem     [0:65535];
   bit   [31:0] ref_mem [0:65535];

   int n_checks = 0;
   int n_pass   = 0;

   dmem_lsu_if bus ();

   dmem_lsu #(.DMEM_DEPTH(DEPTH), .ADDR_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .dmem_addr     (dmem_addr),
      .dmem_data_in  (dmem_data_in),
      .dmem_wr       (dmem_wr),
      .dmem_data_out (dmem_data_out)
   );

   always #5 clk = ~clk;

   // Data memory: whole-word writes, one-cycle registered read, no reset.
   always @(posedge clk) begin
      if (pre_we)       mem[pre_addr]  <= pre_data;
      else if (dmem_wr) mem[dmem_addr] <= dmem_data_in;
      dmem_data_out <= mem[dmem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Behavioural model: error rules, alignment, lane arithmetic, latency.
   function automatic void model(input bit we, input bit [1:0] sz, input bit uns,
                                 input bit [31:0] addr, input bit [31:0] wd,
                                 output bit err, output bit [31:0] rd,
                                 output int lat, output bit [31:0] new_word);
      bit [31:0] w, mask, v;
      int sh, nbits;
      err = (sz == 2'd3) || (addr[31:18] != 0) || (int'(addr[17:2]) >= DEPTH);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 0)) err = 1'b1;
`else
      if (sz == 2'd1) addr[0] = 1'b0;
      if (sz == 2'd2) addr[1:0] = 2'b00;
`endif
      w        = ref_mem[addr[17:2]];
      new_word = w;
      rd       = 32'h0;
      sh       = 8 * int'(addr[1:0]);
      nbits    = 8 << sz;
      mask     = (sz == 2'd2) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
      if (err) begin
         lat = 1;
      end else if (!we) begin
         v = (w >> sh) & mask;
         if (!uns && sz != 2'd2 && v[nbits-1]) v = v | ~mask;
         rd  = v;
         lat = 3;
      end else begin
         new_word = (w & ~(mask << sh)) | ((wd & mask) << sh);
         lat = (sz == 2'd2) ? 2 : 4;
      end
   endfunction

   task automatic do_req(input bit we, input bit [1:0] sz, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wd,
                         output logic [31:0] got_rd, output logic got_err);
      bit e_err;
      bit [31:0] e_rd, e_word;
      int e_lat, lat, wrs, waited;
      logic [15:0] addr_before;
      model(we, sz, uns, addr, wd, e_err, e_rd, e_lat, e_word);
      lat = 0; wrs = 0; waited = 0;
      got_rd = 'x; got_err = 1'bx;
      while (bus.req_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before", {31'b0, bus.req_ready}, 32'd1);
      addr_before      = dmem_addr;
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (dmem_wr === 1'b1) wrs++;
         if (bus.resp_valid === 1'b1) begin
            lat     = k;
            got_rd  = bus.resp_rdata;
            got_err = bus.resp_err;
            break;
         end
      end
      check("latency", 32'(lat), 32'(e_lat));
      check("resp_err", {31'b0, got_err}, {31'b0, e_err});
      check("resp_rdata", got_rd, e_rd);
      check("wr_pulses", 32'(wrs), (we && !e_err) ? 32'd1 : 32'd0);
      @(negedge clk);
      check("resp_one_cycle", {31'b0, bus.resp_valid}, 32'd0);
      check("ready_after", {31'b0, bus.req_ready}, 32'd1);
      if (e_err) check("no_access", {16'h0, dmem_addr}, {16'h0, addr_before});
      if (we && !e_err) begin
         ref_mem[addr[17:2]] = e_word;
         check("mem_word", mem[addr[17:2]], e_word);
      end
   endtask

   task automatic preload(input int idx);
      ref_mem[idx] = $urandom;
      pre_we   = 1'b1;
      pre_addr = 16'(idx);
      pre_data = ref_mem[idx];
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          wrs, rvs, idx;
      bit [31:0]   a;
      bit [1:0]    sz;

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

      // Preload the word pool while reset is held.
      @(negedge clk);
      for (int i = 'h40; i < 'hA0; i++) preload(i);
      preload(32999);
      preload(33000);

      check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_dmem_addr", {16'h0, dmem_addr}, 32'd0);
      check("rst_dmem_data_in", dmem_data_in, 32'd0);
      check("rst_dmem_wr", {31'b0, dmem_wr}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Word store then word load.
      do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, rd, er);
      check("tp1_addr", {16'h0, dmem_addr}, 32'h40);
      do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er);
      check("tp1_load", rd, 32'hDEADBEEF);

      // Sub-word loads.
      do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h80FF7F01, rd, er);
      do_req(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, rd, er);
      check("tp2_b3_signed", rd, 32'hFFFFFF80);
      do_req(1'b0, 2'd1, 1'b1, 32'h200, 32'h0, rd, er);
      check("tp2_h0_unsigned", rd, 32'h00007F01);
      do_req(1'b0, 2'd0, 1'b0, 32'h201, 32'h0, rd, er);
      check("tp2_b1_signed", rd, 32'h0000007F);

      // Byte store read-modify-write.
      do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, rd, er);
      do_req(1'b1, 2'd0, 1'b0, 32'h202, 32'h000000AA, rd, er);
      check("tp3_mem", mem['h80], 32'h11AA3344);

      // Misaligned half load.
      do_req(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
      check("tp4_err", {31'b0, er}, 32'd1);
      check("tp4_rdata", rd, 32'h0);
`else
      check("tp4_err", {31'b0, er}, 32'd0);
      check("tp4_rdata", rd, 32'h0000BEEF);
`endif

      // Out of range and reserved size; last valid word and first invalid word.
      do_req(1'b0, 2'd2, 1'b0, 32'h00040000, 32'h0, rd, er);
      check("tp5_range_err", {31'b0, er}, 32'd1);
      do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, rd, er);
      check("tp5_rsvd_err", {31'b0, er}, 32'd1);
      do_req(1'b0, 2'd2, 1'b0, 32'(33000 * 4), 32'h0, rd, er);
      check("tp5_last_ok", {31'b0, er}, 32'd0);
      do_req(1'b1, 2'd2, 1'b0, 32'(33001 * 4), 32'h12345678, rd, er);
      check("tp5_first_bad", {31'b0, er}, 32'd1);

      // Reset during MERGE of a byte store.
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h241; bus.req_wdata = 32'h5A;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("tp6_ready", {31'b0, bus.req_ready}, 32'd1);
      check("tp6_wr", {31'b0, dmem_wr}, 32'd0);
      rst = 1'b0;
      wrs = 0; rvs = 0;
      for (int k = 0; k < 5; k++) begin
         if (dmem_wr === 1'b1) wrs++;
         if (bus.resp_valid === 1'b1) rvs++;
         @(negedge clk);
      end
      check("tp6_no_wr", 32'(wrs), 32'd0);
      check("tp6_no_resp", 32'(rvs), 32'd0);
      check("tp6_mem", mem['h90], ref_mem['h90]);
      do_req(1'b0, 2'd2, 1'b0, 32'h240, 32'h0, rd, er);
      check("tp6_load", rd, ref_mem['h90]);

      // Randomized traffic.
      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 9))
            0: a = ($urandom_range(0, 1) == 0) ? (32'h00040000 | $urandom)
                                               : 32'((DEPTH + $urandom_range(0, 9)) * 4);
            1: a = 32'(($urandom_range(0, 1) == 0 ? 32999 : 33000) * 4);
            default: begin
               idx = $urandom_range('h40, 'h9F);
               a   = 32'(idx * 4);
            end
         endcase
         if (a[31:18] == 0) a[1:0] = 2'($urandom_range(0, 3));
         sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit that sits directly upstream of the data memory. It is the only master of the dmem port (dmem_addr, dmem_data_in, dmem_wr, dmem_data_out).
- Accepts byte-addressed load/store requests from the CPU over a valid/ready handshake.
- Handles the memory's one-cycle registered read latency.
- Performs read-modify-write for byte and halfword stores, since the memory only writes whole words.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
DMEM_DEPTH, 33001, number of 32-bit words in data memory; word addresses at or above this value are out of range.
ADDR_W, 16, width of the memory word-address port.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle and able to accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or reserved size
dmem_addr  out  16  word address to memory
dmem_data_in  out  32  write data to memory
dmem_wr  out  1  memory write enable
dmem_data_out  in  32  memory read data; valid the cycle after an address is sampled

Behaviour:
- Reset values: all outputs are registered. After reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dmem_addr=0, dmem_data_in=0, dmem_wr=0. State resets to IDLE.
- States: IDLE, RD, MERGE, WR, RESP.
- Accept: a request is accepted when req_valid & req_ready in IDLE. All request fields are latched at acceptance. req_ready=0 in every state except IDLE.
- Error check at accept. Error if any of:
  - req_size==11;
  - half with addr[0]!=0, or word with addr[1:0]!=0;
  - req_addr[31:18]!=0;
  - word address req_addr[17:2] >= DMEM_DEPTH.
  Error path goes IDLE->RESP with resp_err=1, resp_rdata=0. No memory access occurs.
- Load: IDLE->RD, with dmem_addr=req_addr[17:2] and dmem_wr=0. RD->MERGE while memory samples the address. In MERGE, dmem_data_out is valid:
  - byte lane = addr[1:0], half lane = addr[1], little-endian;
  - extend per req_unsigned;
  - register the result into resp_rdata.
  MERGE->RESP. resp_valid is high in the 3rd cycle after the accept edge.
- Word store: IDLE->WR with dmem_wr=1 and dmem_data_in=req_wdata. Write commits at the end of WR. WR->RESP; resp_valid is high 2 cycles after accept.
- Sub-word store: IDLE->RD->MERGE. In MERGE, the selected lane of dmem_data_out is replaced with req_wdata[7:0] or [15:0]; other lanes are preserved; dmem_wr=1 is set for WR. Then WR->RESP; resp_valid is high 4 cycles after accept.
- dmem_wr is high only during WR, for exactly one cycle per store.
- RESP: resp_valid=1 for one cycle, then RESP->IDLE. There is no back-pressure on the response. Next accept is possible the cycle after RESP.
- Reset mid-operation: the next edge with rst=1 forces IDLE and clears all outputs.
  - A write already asserted in WR commits at that same edge, because the memory has no reset.
  - No response is issued for an aborted request.
- Between operations, dmem_addr holds its last value.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses produce resp_err=1 and no memory access.
- Undefined: misaligned addresses are force-aligned (half clears addr[0], word clears addr[1:0]) and complete normally. Out-of-range and reserved-size errors still report resp_err.

Decomposition:
Shared package lsu_pkg holds:
- size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
- the state enum;
- DMEM_DEPTH default.

One natural sub-module, lsu_lane: purely combinational extract/extend (load) and merge (store) for a given size, lane and unsigned flag. It is instantiated once in dmem_lsu.

Test Plan:
1. Word store 0xDEADBEEF @0x100, then word load @0x100 -> dmem_wr pulse with dmem_addr=0x40; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after accept.
2. Sub-word loads from memory word 0x80FF7F01 @0x200 -> byte @0x203 signed = 0xFFFFFF80; half @0x200 unsigned = 0x00007F01; byte @0x201 signed = 0x0000007F.
3. Byte store 0xAA @0x202 over word 0x11223344 -> memory becomes 0x11AA3344; exactly one dmem_wr cycle; resp_valid 4 cycles after accept.
4. Half load @0x101 with macro defined -> resp_err=1, no dmem_wr, no memory read. Macro undefined -> data from 0x100 is returned with resp_err=0.
5. Out-of-range word load @0x00040000 and req_size=11 -> resp_err=1, resp_rdata=0; req_ready returns high 2 cycles after accept.
6. rst asserted during MERGE of a byte store -> memory word unchanged, no resp_valid; req_ready=1 and dmem_wr=0 after the reset edge; a subsequent load completes normally.
